// File: rtl/i2c_mon_pkg.sv
// Shared definitions for the multi-channel I2C START/STOP/byte monitor.
package i2c_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BITS = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam int   BITS_PER_BYTE = 8;
    localparam logic LINE_IDLE     = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser followed by a FILT_LEN-sample glitch filter for one
// open-drain bus line; resets to the idle (released) level.
module i2c_line_filter
    import i2c_mon_pkg::*;
#(
    parameter int FILT_LEN = 4,
    parameter int FCW      = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic line_i,
    output logic line_o
);

    localparam logic [FCW-1:0] CNT_LAST = FCW'(FILT_LEN - 1);

    logic           sync1_q;
    logic           sync2_q;
    logic           filt_q;
    logic           filt_d;
    logic [FCW-1:0] cnt_q;
    logic [FCW-1:0] cnt_d;

    // Filtered value follows the sample only after FILT_LEN consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = {FCW{1'b0}};
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
                cnt_d  = {FCW{1'b0}};
            end else begin
                cnt_d = cnt_q + FCW'(1);
            end
        end else begin
            cnt_d = {FCW{1'b0}};
        end
    end

    // Synchroniser, filter counter and filtered value registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= LINE_IDLE;
            sync2_q <= LINE_IDLE;
            filt_q  <= LINE_IDLE;
            cnt_q   <= {FCW{1'b0}};
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign line_o = filt_q;

endmodule

// File: rtl/i2c_cond_det.sv
// Passive NCH-channel I2C monitor: START/rSTART/STOP pulses, busy level, bytes
// and ACK bits. Optional SCL-low timeout is built only when I2C_TIMEOUT_EN is defined.
module i2c_cond_det
    import i2c_mon_pkg::*;
#(
    parameter int NCH      = 1,
    parameter int FILT_LEN = 4,
    parameter int FCW      = 8
`ifdef I2C_TIMEOUT_EN
    , parameter int TO_CYC = 65536
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   sda_i,
    input  logic [NCH-1:0]   scl_i,
    output logic [NCH-1:0]   start_o,
    output logic [NCH-1:0]   rstart_o,
    output logic [NCH-1:0]   stop_o,
    output logic [NCH-1:0]   busy_o,
    output logic [NCH-1:0]   byte_vld_o,
    output logic [8*NCH-1:0] byte_o,
    output logic [NCH-1:0]   ack_vld_o,
    output logic [NCH-1:0]   ack_o,
    output logic [NCH-1:0]   timeout_o
);

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic       sda_f, scl_f, sda_p_q, scl_p_q;
        logic       start_c, stop_c, scl_rise_c, to_hit;
        state_e     state_q, state_d;
        logic [3:0] bit_cnt_q, bit_cnt_d;
        logic [6:0] shreg_q, shreg_d;
        logic [7:0] byte_q, byte_d;
        logic       ack_q, ack_d, busy_q, busy_d;
        logic       start_q, start_d, rstart_q, rstart_d, stop_q, stop_d;
        logic       bvld_q, bvld_d, avld_q, avld_d;

        i2c_line_filter #(.FILT_LEN(FILT_LEN), .FCW(FCW)) u_sda_filt (
            .clk_i(clk), .reset_i(reset), .line_i(sda_i[ch]), .line_o(sda_f)
        );
        i2c_line_filter #(.FILT_LEN(FILT_LEN), .FCW(FCW)) u_scl_filt (
            .clk_i(clk), .reset_i(reset), .line_i(scl_i[ch]), .line_o(scl_f)
        );

        // Requiring SCL stable across the sample pair turns coincident SDA/SCL edges into data.
        assign start_c    = sda_p_q & ~sda_f & scl_p_q & scl_f;
        assign stop_c     = ~sda_p_q & sda_f & scl_p_q & scl_f;
        assign scl_rise_c = ~scl_p_q & scl_f;

`ifdef I2C_TIMEOUT_EN
        localparam int TOW = $clog2(TO_CYC + 1);
        logic [TOW-1:0] to_cnt_q, to_cnt_d;
        logic           tout_q;

        assign to_hit = busy_q & ~scl_f & (to_cnt_q == TOW'(TO_CYC - 1));

        // SCL-low cycle counter, only meaningful while a transfer is in progress.
        always_comb begin
            to_cnt_d = {TOW{1'b0}};
            if (busy_q && !scl_f && !to_hit) begin
                to_cnt_d = to_cnt_q + TOW'(1);
            end else begin
                to_cnt_d = {TOW{1'b0}};
            end
        end

        // Timeout counter and pulse registers.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                to_cnt_q <= {TOW{1'b0}};
                tout_q   <= 1'b0;
            end else begin
                to_cnt_q <= to_cnt_d;
                tout_q   <= to_hit;
            end
        end

        assign timeout_o[ch] = tout_q;
`else
        assign to_hit        = 1'b0;
        assign timeout_o[ch] = 1'b0;
`endif

        // State register together with the edge history and registered outputs.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sda_p_q   <= LINE_IDLE;
                scl_p_q   <= LINE_IDLE;
                state_q   <= IDLE;
                bit_cnt_q <= 4'd0;
                shreg_q   <= 7'd0;
                byte_q    <= 8'd0;
                ack_q     <= 1'b0;
                busy_q    <= 1'b0;
                start_q   <= 1'b0;
                rstart_q  <= 1'b0;
                stop_q    <= 1'b0;
                bvld_q    <= 1'b0;
                avld_q    <= 1'b0;
            end else begin
                sda_p_q   <= sda_f;
                scl_p_q   <= scl_f;
                state_q   <= state_d;
                bit_cnt_q <= bit_cnt_d;
                shreg_q   <= shreg_d;
                byte_q    <= byte_d;
                ack_q     <= ack_d;
                busy_q    <= busy_d;
                start_q   <= start_d;
                rstart_q  <= rstart_d;
                stop_q    <= stop_d;
                bvld_q    <= bvld_d;
                avld_q    <= avld_d;
            end
        end

        // Next-state logic: STOP/timeout win, then START, then SCL-driven bit progress.
        always_comb begin
            state_d = state_q;
            if (stop_c || to_hit) begin
                state_d = IDLE;
            end else if (start_c) begin
                state_d = BITS;
            end else begin
                case (state_q)
                    IDLE:    state_d = IDLE;
                    BITS:    state_d = (scl_rise_c && bit_cnt_q == 4'(BITS_PER_BYTE - 1)) ? ACK : BITS;
                    ACK:     state_d = scl_rise_c ? BITS : ACK;
                    default: state_d = IDLE;
                endcase
            end
        end

        // Output/datapath next values; byte_o and ack_o hold between updates.
        always_comb begin
            bit_cnt_d = bit_cnt_q;
            shreg_d   = shreg_q;
            byte_d    = byte_q;
            ack_d     = ack_q;
            busy_d    = busy_q;
            start_d   = 1'b0;
            rstart_d  = 1'b0;
            stop_d    = 1'b0;
            bvld_d    = 1'b0;
            avld_d    = 1'b0;
            if (stop_c) begin
                stop_d    = 1'b1;
                busy_d    = 1'b0;
                bit_cnt_d = 4'd0;
            end else if (to_hit) begin
                busy_d    = 1'b0;
                bit_cnt_d = 4'd0;
            end else if (start_c) begin
                start_d   = (state_q == IDLE);
                rstart_d  = (state_q != IDLE);
                busy_d    = 1'b1;
                bit_cnt_d = 4'd0;
            end else if (scl_rise_c) begin
                case (state_q)
                    BITS: begin
                        shreg_d   = {shreg_q[5:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'(BITS_PER_BYTE - 1)) begin
                            byte_d = {shreg_q, sda_f};
                            bvld_d = 1'b1;
                        end else begin
                            bvld_d = 1'b0;
                        end
                    end
                    ACK: begin
                        ack_d     = sda_f;
                        avld_d    = 1'b1;
                        bit_cnt_d = 4'd0;
                    end
                    default: bit_cnt_d = bit_cnt_q;
                endcase
            end else begin
                bit_cnt_d = bit_cnt_q;
            end
        end

        assign start_o[ch]        = start_q;
        assign rstart_o[ch]       = rstart_q;
        assign stop_o[ch]         = stop_q;
        assign busy_o[ch]         = busy_q;
        assign byte_vld_o[ch]     = bvld_q;
        assign byte_o[8*ch +: 8]  = byte_q;
        assign ack_vld_o[ch]      = avld_q;
        assign ack_o[ch]          = ack_q;
    end

endmodule

// File: tb/tb_i2c_cond_det.sv
// Self-checking bench for i2c_cond_det: transaction-level event scoreboard,
// vector table, random transfers and directed corner sequences.
module tb_i2c_cond_det;

    localparam int NCH = 2;
    localparam int FL  = 4;

    localparam int EV_START  = 1 << 8;
    localparam int EV_RSTART = 2 << 8;
    localparam int EV_BYTE   = 3 << 8;
    localparam int EV_ACK    = 4 << 8;
    localparam int EV_STOP   = 5 << 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH-1:0]   sda, scl;
    logic [NCH-1:0]   start_o, rstart_o, stop_o, busy_o, byte_vld_o, ack_vld_o, ack_o, timeout_o;
    logic [8*NCH-1:0] byte_o;

    i2c_cond_det #(
        .NCH(NCH), .FILT_LEN(FL), .FCW(8)
`ifdef I2C_TIMEOUT_EN
        , .TO_CYC(1000)
`endif
    ) dut (
        .clk(clk), .reset(reset), .sda_i(sda), .scl_i(scl),
        .start_o(start_o), .rstart_o(rstart_o), .stop_o(stop_o), .busy_o(busy_o),
        .byte_vld_o(byte_vld_o), .byte_o(byte_o), .ack_vld_o(ack_vld_o),
        .ack_o(ack_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0, n_bad = 0;
    int st_n[NCH] = '{default: 0};
    int rs_n[NCH] = '{default: 0};
    int sp_n[NCH] = '{default: 0};
    int bv_n[NCH] = '{default: 0};
    int to_n[NCH] = '{default: 0};
    int last_st_cyc[NCH] = '{default: 0};
    int both_start = 0;
    int busy_err = 0;
    logic exp_busy[NCH] = '{default: 1'b0};
    int obs[$];
    int expq[$];
    int b_st, b_rs, b_sp, b_bv, b_to, b_both, b_sp1;

    typedef struct {
        logic [7:0] d;
        logic       a;
        int         h;
    } vec_t;
    vec_t tbl[6];

    // Observer: counts pulses, checks busy against the START..STOP window, logs channel 0 events.
    always @(negedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) exp_busy[c] = 1'b0;
        end else begin
            if (start_o == 2'b11) both_start++;
            for (int c = 0; c < NCH; c++) begin
                if (start_o[c])    begin st_n[c]++; last_st_cyc[c] = cyc; exp_busy[c] = 1'b1; end
                if (rstart_o[c])   begin rs_n[c]++; exp_busy[c] = 1'b1; end
                if (byte_vld_o[c]) bv_n[c]++;
                if (stop_o[c])     begin sp_n[c]++; exp_busy[c] = 1'b0; end
                if (timeout_o[c])  begin to_n[c]++; exp_busy[c] = 1'b0; end
                if (busy_o[c] !== exp_busy[c]) busy_err++;
            end
            if (start_o[0])    obs.push_back(EV_START);
            if (rstart_o[0])   obs.push_back(EV_RSTART);
            if (byte_vld_o[0]) obs.push_back(EV_BYTE | int'(byte_o[7:0]));
            if (ack_vld_o[0])  obs.push_back(EV_ACK | int'(ack_o[0]));
            if (stop_o[0])     obs.push_back(EV_STOP);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_st = st_n[0]; b_rs = rs_n[0]; b_sp = sp_n[0]; b_bv = bv_n[0];
        b_to = to_n[0]; b_both = both_start; b_sp1 = sp_n[1];
    endtask

    task automatic cmp_events(input string nm);
        chk({nm, "_count"}, obs.size(), expq.size());
        for (int i = 0; i < obs.size() && i < expq.size(); i++) chk({nm, "_event"}, obs[i], expq[i]);
        obs.delete();
        expq.delete();
    endtask

    task automatic bus_start(input int c, input int h);
        sda[c] = 1'b0; tick(h);
        scl[c] = 1'b0; tick(h / 2);
    endtask

    task automatic bus_bit(input int c, input logic b, input int h);
        sda[c] = b;    tick(h);
        scl[c] = 1'b1; tick(h);
        scl[c] = 1'b0; tick(h / 2);
    endtask

    task automatic bus_rstart(input int c, input int h);
        sda[c] = 1'b1; tick(h);
        scl[c] = 1'b1; tick(h);
        bus_start(c, h);
    endtask

    task automatic bus_stop(input int c, input int h);
        sda[c] = 1'b0; tick(h);
        scl[c] = 1'b1; tick(h);
        sda[c] = 1'b1; tick(h);
    endtask

    task automatic bus_byte(input int c, input logic [7:0] d, input logic a, input int h);
        for (int i = 7; i >= 0; i--) bus_bit(c, d[i], h);
        bus_bit(c, a, h);
    endtask

    initial begin
        int t0, nb, k, h;
        logic [7:0] d;
        logic a;

        tbl[0] = '{8'h00, 1'b0, 8};
        tbl[1] = '{8'hFF, 1'b1, 10};
        tbl[2] = '{8'h5A, 1'b0, 12};
        tbl[3] = '{8'h80, 1'b1, 16};
        tbl[4] = '{8'h01, 1'b0, 9};
        tbl[5] = '{8'hC3, 1'b1, 20};

        reset = 1'b1; sda = '1; scl = '1;
        tick(3);
        chk("reset_outputs", 32'({start_o, rstart_o, stop_o, busy_o, byte_vld_o, ack_vld_o, ack_o, timeout_o, byte_o}), 0);
        reset = 1'b0;
        tick(100);
        chk("idle_outputs", 32'({start_o, rstart_o, stop_o, busy_o, byte_vld_o, ack_vld_o, ack_o, timeout_o, byte_o}), 0);
        chk("idle_events", obs.size(), 0);

        // START, 0xA5, ACK=0, STOP with a 20-cycle half period; START latency FILT_LEN+3.
        expq = '{EV_START, EV_BYTE | 8'hA5, EV_ACK | 0, EV_STOP};
        t0 = cyc;
        bus_start(0, 20);
        chk("start_latency", last_st_cyc[0], t0 + FL + 3);
        chk("busy_after_start", int'(busy_o[0]), 1);
        bus_byte(0, 8'hA5, 1'b0, 20);
        bus_stop(0, 20);
        cmp_events("a5_xfer");
        chk("busy_after_stop", int'(busy_o[0]), 0);

        // SDA glitch shorter than FILT_LEN is rejected; exactly FILT_LEN is accepted.
        snap();
        sda[0] = 1'b0; tick(FL - 1); sda[0] = 1'b1; tick(20);
        chk("glitch3_no_start", st_n[0] - b_st, 0);
        chk("glitch3_events", obs.size(), 0);
        expq = '{EV_START, EV_STOP};
        sda[0] = 1'b0; tick(FL); sda[0] = 1'b1; tick(20);
        chk("glitch4_start", st_n[0] - b_st, 1);
        cmp_events("glitch4");

        // START, 5 bits, repeated START, 0x3C, STOP.
        snap();
        expq = '{EV_START, EV_RSTART, EV_BYTE | 8'h3C, EV_ACK | 1, EV_STOP};
        bus_start(0, 10);
        for (int i = 0; i < 5; i++) bus_bit(0, 1'(i & 1), 10);
        bus_rstart(0, 10);
        bus_byte(0, 8'h3C, 1'b1, 10);
        bus_stop(0, 10);
        chk("rs_start_once", st_n[0] - b_st, 1);
        chk("rs_rstart_once", rs_n[0] - b_rs, 1);
        chk("rs_byte_once", bv_n[0] - b_bv, 1);
        cmp_events("rstart_seq");

        // Table of single-byte transfers.
        for (int v = 0; v < 6; v++) begin
            expq = '{EV_START, EV_BYTE | int'(tbl[v].d), EV_ACK | int'(tbl[v].a), EV_STOP};
            bus_start(0, tbl[v].h);
            bus_byte(0, tbl[v].d, tbl[v].a, tbl[v].h);
            bus_stop(0, tbl[v].h);
            cmp_events("table");
            chk("table_byte_hold", int'(byte_o[7:0]), int'(tbl[v].d));
        end

        // Both channels START in the same cycle, then STOP only on channel 1.
        snap();
        expq = '{EV_START, EV_STOP};
        sda = 2'b00; tick(20);
        chk("dual_start_same_cycle", both_start - b_both, 1);
        chk("dual_busy_both", int'(busy_o), 2'b11);
        sda[1] = 1'b1; tick(20);
        chk("dual_busy_ch0_only", int'(busy_o), 2'b01);
        chk("dual_stop_ch1", sp_n[1] - b_sp1, 1);
        sda[0] = 1'b1; tick(20);
        chk("dual_busy_none", int'(busy_o), 0);
        cmp_events("dual_ch0");

        // Randomised transfers against the transaction-level expectation.
        for (int t = 0; t < 20; t++) begin
            h = $urandom_range(8, 14);
            k = $urandom_range(1, FL - 1);
            if ($urandom_range(0, 1) == 1) begin
                sda[0] = 1'b0; tick(k); sda[0] = 1'b1;
            end else begin
                scl[0] = 1'b0; tick(k); scl[0] = 1'b1;
            end
            tick(12);
            expq.push_back(EV_START);
            bus_start(0, h);
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    k = $urandom_range(1, 7);
                    for (int i = 0; i < k; i++) bus_bit(0, 1'($urandom_range(0, 1)), h);
                    bus_rstart(0, h);
                    expq.push_back(EV_RSTART);
                end
                d = 8'($urandom_range(0, 255));
                a = 1'($urandom_range(0, 1));
                bus_byte(0, d, a, h);
                expq.push_back(EV_BYTE | int'(d));
                expq.push_back(EV_ACK | int'(a));
            end
            bus_stop(0, h);
            expq.push_back(EV_STOP);
            cmp_events("random");
        end

        // Reset in the middle of a byte abandons it silently.
        snap();
        expq = '{EV_START};
        bus_start(0, 10);
        for (int i = 0; i < 4; i++) bus_bit(0, 1'b1, 10);
        reset = 1'b1; sda = '1; scl = '1; tick(3);
        reset = 1'b0; tick(20);
        chk("midreset_no_byte", bv_n[0] - b_bv, 0);
        chk("midreset_busy", int'(busy_o[0]), 0);
        cmp_events("midreset");

        // SCL held low after START.
        snap();
        expq = '{EV_START, EV_STOP};
        bus_start(0, 10);
        tick(1100);
`ifdef I2C_TIMEOUT_EN
        chk("timeout_pulse_once", to_n[0] - b_to, 1);
        chk("timeout_busy_cleared", int'(busy_o[0]), 0);
        chk("timeout_no_stop", sp_n[0] - b_sp, 0);
`else
        chk("timeout_absent", to_n[0] - b_to, 0);
        chk("timeout_busy_held", int'(busy_o[0]), 1);
`endif
        scl[0] = 1'b1; tick(10);
        sda[0] = 1'b1; tick(20);
        chk("cleanup_stop", sp_n[0] - b_sp, 1);
        chk("cleanup_busy", int'(busy_o[0]), 0);
        cmp_events("timeout_seq");

        chk("busy_window", busy_err, 0);
        chk("ch1_no_rstart", rs_n[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
